// File: rtl/spi_host_pkg.sv
// Shared types and helpers for the PSEC6 configuration-port SPI host.
package spi_host_pkg;

    localparam int FRAME_BITS = 16;
    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    // Reads carry a zero data byte; the chip returns its register on poci instead.
    function automatic logic [FRAME_BITS-1:0] pack_frame(
        input logic              write,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] wdata
    );
        return {write, addr, write ? wdata : {DATA_W{1'b0}}};
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// Mode-0 serial clock generator: CLK_DIV clk cycles per half-period while enabled.
module spi_sclk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic spi_clk,
    output logic rise,
    output logic fall
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] half_cnt;
    logic          phase_end;

    // Strobes flag the clk edge on which spi_clk is about to change.
    assign phase_end = en && (half_cnt == '0);
    assign rise      = phase_end && !spi_clk;
    assign fall      = phase_end && spi_clk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spi_clk  <= 1'b0;
            half_cnt <= '0;
        end else if (!en) begin
            spi_clk  <= 1'b0;
            half_cnt <= '0;
        end else if (phase_end) begin
            spi_clk  <= ~spi_clk;
            half_cnt <= CW'(CLK_DIV - 1);
        end else begin
            half_cnt <= half_cnt - CW'(1);
        end
    end

endmodule

// File: rtl/spi_host_ctrl.sv
// SPI host for the PSEC6 configuration port: one 16-bit {rw, addr, data} frame per command.
module spi_host_ctrl
    import spi_host_pkg::*;
#(
    parameter int CLK_DIV   = 2,
    parameter int CSB_SETUP = 2,
    parameter int CSB_HOLD  = 2,
    parameter int CSB_GAP   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic [7:0] rdata,
    output logic       rdata_valid,
    output logic       busy,
    output logic       spi_clk,
    output logic       csb,
    output logic       pico,
    input  logic       poci
);

    localparam int CNT_W = 8;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [3:0]              bit_cnt;
    logic [FRAME_BITS-2:0]   tx_shreg;
    logic [DATA_W-1:0]       rx_shreg;
    logic                    is_read;
    logic [FRAME_BITS-1:0]   frame_in;
    logic                    sclk_en;
    logic                    rise;
    logic                    fall;

    assign frame_in = pack_frame(cmd_write, cmd_addr, cmd_wdata);

    // Enabled one cycle early so the first rise lands on the edge that ends SETUP.
    assign sclk_en = (state == SHIFT) || ((state == SETUP) && (cnt == '0));

    spi_sclk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sclk_gen (
        .clk    (clk),
        .rst    (rst),
        .en     (sclk_en),
        .spi_clk(spi_clk),
        .rise   (rise),
        .fall   (fall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_cnt     <= '0;
            tx_shreg    <= '0;
            rx_shreg    <= '0;
            is_read     <= 1'b0;
            csb         <= 1'b1;
            pico        <= 1'b0;
            cmd_ready   <= 1'b1;
            busy        <= 1'b0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
        end else begin
            rdata_valid <= 1'b0;
            // Only the last DATA_W captured bits survive; the address-phase bits fall off.
            if (rise)
                rx_shreg <= {rx_shreg[DATA_W-2:0], poci};

            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        tx_shreg  <= frame_in[FRAME_BITS-2:0];
                        pico      <= frame_in[FRAME_BITS-1];
                        is_read   <= !cmd_write;
                        csb       <= 1'b0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        cnt       <= CNT_W'(CSB_SETUP - 1);
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == '0)
                        state <= SHIFT;
                    else
                        cnt <= cnt - CNT_W'(1);
                end
                SHIFT: begin
                    if (fall) begin
                        if (bit_cnt == 4'd15) begin
                            // HOLD also absorbs the trailing low half-period of bit 16.
                            bit_cnt <= '0;
                            cnt     <= CNT_W'(CLK_DIV + CSB_HOLD - 1);
                            state   <= HOLD;
                        end else begin
                            bit_cnt  <= bit_cnt + 4'd1;
                            pico     <= tx_shreg[FRAME_BITS-2];
                            tx_shreg <= {tx_shreg[FRAME_BITS-3:0], 1'b0};
                        end
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        csb   <= 1'b1;
                        cnt   <= CNT_W'(CSB_GAP - 1);
                        state <= GAP;
                        if (is_read) begin
                            rdata       <= rx_shreg;
                            rdata_valid <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt == '0) begin
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_host_ctrl.sv
// Directed bench for spi_host_ctrl: default timing instance plus a CLK_DIV=1 instance.
module tb_spi_host_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       cmd_valid_a = 1'b0, cmd_write_a = 1'b0;
    logic [6:0] cmd_addr_a  = '0;
    logic [7:0] cmd_wdata_a = '0;
    logic       cmd_ready_a, rdata_valid_a, busy_a, spi_clk_a, csb_a, pico_a, poci_a;
    logic [7:0] rdata_a;

    logic       cmd_valid_b = 1'b0, cmd_write_b = 1'b0;
    logic [6:0] cmd_addr_b  = '0;
    logic [7:0] cmd_wdata_b = '0;
    logic       cmd_ready_b, rdata_valid_b, busy_b, spi_clk_b, csb_b, pico_b;
    logic       poci_b = 1'b0;
    logic [7:0] rdata_b;

    int checks   = 0;
    int failures = 0;

    spi_host_ctrl #(
        .CLK_DIV(2), .CSB_SETUP(2), .CSB_HOLD(2), .CSB_GAP(4)
    ) dut_a (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a), .cmd_write(cmd_write_a),
        .cmd_addr(cmd_addr_a), .cmd_wdata(cmd_wdata_a),
        .rdata(rdata_a), .rdata_valid(rdata_valid_a), .busy(busy_a),
        .spi_clk(spi_clk_a), .csb(csb_a), .pico(pico_a), .poci(poci_a)
    );

    spi_host_ctrl #(
        .CLK_DIV(1), .CSB_SETUP(2), .CSB_HOLD(2), .CSB_GAP(4)
    ) dut_b (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_write(cmd_write_b),
        .cmd_addr(cmd_addr_b), .cmd_wdata(cmd_wdata_b),
        .rdata(rdata_b), .rdata_valid(rdata_valid_b), .busy(busy_b),
        .spi_clk(spi_clk_b), .csb(csb_b), .pico(pico_b), .poci(poci_b)
    );

    // Chip model: mode 0, first bit valid at csb fall, next bit after each sclk fall.
    logic [7:0]  chip_byte = 8'h00;
    logic [3:0]  chip_idx  = 4'd0;
    logic [15:0] chip_word;
    assign chip_word = {8'h00, chip_byte};
    assign poci_a    = csb_a ? 1'b0 : chip_word[4'd15 - chip_idx];

    always @(posedge csb_a or negedge spi_clk_a)
        if (csb_a) chip_idx <= 4'd0;
        else       chip_idx <= chip_idx + 4'd1;

    logic [15:0] mon_frame_a, mon_frame_b;
    int          mon_rises_a = 0, mon_rises_b = 0;

    always @(negedge csb_a or posedge spi_clk_a)
        if (spi_clk_a) begin
            mon_frame_a <= {mon_frame_a[14:0], pico_a};
            mon_rises_a <= mon_rises_a + 1;
        end else begin
            mon_frame_a <= '0;
            mon_rises_a <= 0;
        end

    always @(negedge csb_b or posedge spi_clk_b)
        if (spi_clk_b) begin
            mon_frame_b <= {mon_frame_b[14:0], pico_b};
            mon_rises_b <= mon_rises_b + 1;
        end else begin
            mon_frame_b <= '0;
            mon_rises_b <= 0;
        end

    task automatic run_frame_a(input logic w, input logic [6:0] a, input logic [7:0] d,
                               output int low, output int rv, output logic rv_at_rise);
        logic prev_csb;
        low = 0; rv = 0; rv_at_rise = 1'b0; prev_csb = 1'b1;
        @(negedge clk);
        cmd_write_a = w; cmd_addr_a = a; cmd_wdata_a = d; cmd_valid_a = 1'b1;
        @(negedge clk);
        cmd_valid_a = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!csb_a) low++;
            if (rdata_valid_a) rv++;
            if (csb_a && !prev_csb) rv_at_rise = rdata_valid_a;
            prev_csb = csb_a;
            if (!busy_a) break;
            @(negedge clk);
        end
        checks++;
        if (busy_a !== 1'b0) begin
            failures++;
            $display("FAIL frame_timeout: busy=%b required 0 within 400 cycles", busy_a);
        end
    endtask

    task automatic test_reset;
        checks += 7;
        if (csb_a !== 1'b1)        begin failures++; $display("FAIL reset_csb: got %b want 1", csb_a); end
        if (spi_clk_a !== 1'b0)    begin failures++; $display("FAIL reset_spi_clk: got %b want 0", spi_clk_a); end
        if (pico_a !== 1'b0)       begin failures++; $display("FAIL reset_pico: got %b want 0", pico_a); end
        if (cmd_ready_a !== 1'b1)  begin failures++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready_a); end
        if (busy_a !== 1'b0)       begin failures++; $display("FAIL reset_busy: got %b want 0", busy_a); end
        if (rdata_a !== 8'h00)     begin failures++; $display("FAIL reset_rdata: got %h want 00", rdata_a); end
        if (rdata_valid_a !== 1'b0) begin failures++; $display("FAIL reset_rdata_valid: got %b want 0", rdata_valid_a); end
    endtask

    task automatic test_write;
        int low, rv; logic rr;
        run_frame_a(1'b1, 7'd3, 8'hA5, low, rv, rr);
        checks += 5;
        if (mon_frame_a !== 16'h83A5) begin failures++; $display("FAIL write_frame: got %h want 83a5", mon_frame_a); end
        if (mon_rises_a != 16) begin failures++; $display("FAIL write_rises: got %0d want 16", mon_rises_a); end
        if (low != 68)         begin failures++; $display("FAIL write_csb_low: got %0d want 68", low); end
        if (rv != 0)           begin failures++; $display("FAIL write_rdata_valid: got %0d pulses want 0", rv); end
        if (rdata_a !== 8'h00) begin failures++; $display("FAIL write_rdata_hold: got %h want 00", rdata_a); end
    endtask

    task automatic test_read;
        int low, rv; logic rr;
        chip_byte = 8'h3C;
        run_frame_a(1'b0, 7'd5, 8'hFF, low, rv, rr);
        checks += 6;
        if (mon_frame_a !== 16'h0500) begin failures++; $display("FAIL read_frame: got %h want 0500", mon_frame_a); end
        if (mon_rises_a != 16) begin failures++; $display("FAIL read_rises: got %0d want 16", mon_rises_a); end
        if (low != 68)         begin failures++; $display("FAIL read_csb_low: got %0d want 68", low); end
        if (rv != 1)           begin failures++; $display("FAIL read_valid_pulses: got %0d want 1", rv); end
        if (rr !== 1'b1)       begin failures++; $display("FAIL read_valid_at_csb_rise: got %b want 1", rr); end
        if (rdata_a !== 8'h3C) begin failures++; $display("FAIL read_rdata: got %h want 3c", rdata_a); end
    endtask

    task automatic test_back_to_back;
        int acc0, acc1, n, hi_run, last_gap;
        logic seen_low;
        acc0 = 0; acc1 = 0; n = 0; hi_run = 0; last_gap = 0; seen_low = 1'b0;
        @(negedge clk);
        cmd_write_a = 1'b1; cmd_addr_a = 7'd1; cmd_wdata_a = 8'h11; cmd_valid_a = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if (n == 2 && c == acc1 + 1) cmd_valid_a = 1'b0;
            if (n == 1 && c == acc0 + 1) begin cmd_addr_a = 7'd2; cmd_wdata_a = 8'h22; end
            if (cmd_valid_a && cmd_ready_a) begin
                if (n == 0) acc0 = c; else acc1 = c;
                n++;
            end
            if (csb_a) hi_run++;
            else begin
                if (seen_low && hi_run > 0) last_gap = hi_run;
                hi_run = 0;
                seen_low = 1'b1;
            end
            if (n == 2 && c > acc1 + 1 && !busy_a) break;
            @(negedge clk);
        end
        cmd_valid_a = 1'b0;
        checks += 6;
        if (n != 2)              begin failures++; $display("FAIL b2b_accepts: got %0d want 2", n); end
        if (acc1 - acc0 != 73)   begin failures++; $display("FAIL b2b_spacing: got %0d want 73", acc1 - acc0); end
        if (last_gap != 5)       begin failures++; $display("FAIL b2b_csb_gap: got %0d want 5", last_gap); end
        if (mon_frame_a !== 16'h8222) begin failures++; $display("FAIL b2b_frame2: got %h want 8222", mon_frame_a); end
        if (mon_rises_a != 16)   begin failures++; $display("FAIL b2b_rises: got %0d want 16", mon_rises_a); end
        if (rdata_a !== 8'h3C)   begin failures++; $display("FAIL b2b_rdata_hold: got %h want 3c", rdata_a); end
    endtask

    task automatic test_abort;
        int low, rv; logic rr, reached;
        reached = 1'b0;
        chip_byte = 8'h77;
        @(negedge clk);
        cmd_write_a = 1'b0; cmd_addr_a = 7'd5; cmd_valid_a = 1'b1;
        @(negedge clk);
        cmd_valid_a = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (mon_rises_a == 7 && spi_clk_a) begin reached = 1'b1; break; end
        end
        checks++;
        if (reached !== 1'b1) begin failures++; $display("FAIL abort_reach_bit7: got %b want 1", reached); end
        rst = 1'b1;
        #1;
        checks += 5;
        if (csb_a !== 1'b1)         begin failures++; $display("FAIL abort_csb: got %b want 1", csb_a); end
        if (spi_clk_a !== 1'b0)     begin failures++; $display("FAIL abort_spi_clk: got %b want 0", spi_clk_a); end
        if (rdata_valid_a !== 1'b0) begin failures++; $display("FAIL abort_rdata_valid: got %b want 0", rdata_valid_a); end
        if (cmd_ready_a !== 1'b1)   begin failures++; $display("FAIL abort_cmd_ready: got %b want 1", cmd_ready_a); end
        if (rdata_a !== 8'h00)      begin failures++; $display("FAIL abort_rdata_clear: got %h want 00", rdata_a); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chip_byte = 8'h5A;
        run_frame_a(1'b0, 7'd6, 8'h00, low, rv, rr);
        checks += 4;
        if (mon_frame_a !== 16'h0600) begin failures++; $display("FAIL abort_next_frame: got %h want 0600", mon_frame_a); end
        if (mon_rises_a != 16)   begin failures++; $display("FAIL abort_next_rises: got %0d want 16", mon_rises_a); end
        if (rv != 1)             begin failures++; $display("FAIL abort_next_valid: got %0d want 1", rv); end
        if (rdata_a !== 8'h5A)   begin failures++; $display("FAIL abort_next_rdata: got %h want 5a", rdata_a); end
    endtask

    task automatic test_clkdiv1;
        int low, toggles, first_t, last_t;
        logic prev_clk;
        low = 0; toggles = 0; first_t = -1; last_t = -1;
        @(negedge clk);
        cmd_write_b = 1'b1; cmd_addr_b = 7'd8; cmd_wdata_b = 8'hFF; cmd_valid_b = 1'b1;
        @(negedge clk);
        cmd_valid_b = 1'b0;
        prev_clk = spi_clk_b;
        for (int c = 0; c < 200; c++) begin
            if (!csb_b) low++;
            if (spi_clk_b !== prev_clk) begin
                toggles++;
                if (first_t < 0) first_t = c;
                last_t = c;
            end
            prev_clk = spi_clk_b;
            if (!busy_b) break;
            @(negedge clk);
        end
        checks += 5;
        if (mon_frame_b !== 16'h88FF)  begin failures++; $display("FAIL div1_frame: got %h want 88ff", mon_frame_b); end
        if (mon_rises_b != 16)         begin failures++; $display("FAIL div1_rises: got %0d want 16", mon_rises_b); end
        if (low != 36)                 begin failures++; $display("FAIL div1_csb_low: got %0d want 36", low); end
        if (toggles != 32)             begin failures++; $display("FAIL div1_toggles: got %0d want 32", toggles); end
        if (last_t - first_t != 31)    begin failures++; $display("FAIL div1_toggle_span: got %0d want 31", last_t - first_t); end
    endtask

    initial begin
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_write();
        test_read();
        test_back_to_back();
        test_abort();
        test_clkdiv1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
